// File: rtl/cnn_acc_pkg.sv
// rtl/cnn_acc_pkg.sv - shared widths and FSM state encoding for the conv accumulator
package cnn_acc_pkg;

    localparam int PROD_W = 22;
    localparam int OUT_W  = 8;
    localparam int BIAS_W = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

endpackage

// File: rtl/cnn_requant_sat.sv
// rtl/cnn_requant_sat.sv - round-half-up shift and clamp of a window sum (CNN_ACC_RELU_EN selects ReLU clamp)
module cnn_requant_sat
    import cnn_acc_pkg::*;
#(
    parameter int SHIFT = 6,
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] q
);

    localparam logic [ACC_W-1:0]        HALF = ACC_W'(64'd1 << (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(127);
`ifndef CNN_ACC_RELU_EN
    localparam logic signed [ACC_W-1:0] MINV = ~ACC_W'(127);
`endif

    logic [ACC_W-1:0]        rnd;
    logic signed [ACC_W-1:0] r;

    // round half up, arithmetic shift, then clamp into the 8-bit activation range
    always_comb begin
        rnd = sum + HALF;
        r   = $signed(rnd) >>> SHIFT;
`ifdef CNN_ACC_RELU_EN
        if (r < 0)
            q = '0;
        else if (r > MAXV)
            q = 8'd127;
        else
            q = r[OUT_W-1:0];
`else
        if (r < MINV)
            q = 8'h80;
        else if (r > MAXV)
            q = 8'd127;
        else
            q = r[OUT_W-1:0];
`endif
    end

endmodule

// File: rtl/cnn_conv_acc_relu.sv
// rtl/cnn_conv_acc_relu.sv - windowed product accumulator with bias and requantized output (CNN_ACC_RELU_EN selects ReLU clamp)
module cnn_conv_acc_relu
    import cnn_acc_pkg::*;
#(
    parameter int ACC_LEN = 9,
    parameter int SHIFT   = 6,
    parameter int ACC_W   = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [BIAS_W-1:0] bias_in,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(ACC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             beat;
    logic             drain;
    logic             first;
    logic             last;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] bias_ext;
    logic [ACC_W-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [OUT_W-1:0] q;

    assign prod_ready = (state != OUT) || out_ready;
    assign beat       = prod_valid && prod_ready;
    assign drain      = out_valid && out_ready;
    assign prod_ext   = {{(ACC_W - PROD_W){prod_in[PROD_W-1]}}, prod_in};
    assign bias_ext   = {{(ACC_W - BIAS_W){bias_in[BIAS_W-1]}}, bias_in};

    // a window opens from IDLE, or from OUT when the pending result leaves in the same cycle
    always_comb begin
        first   = beat && ((state == IDLE) || ((state == OUT) && drain));
        sum_nxt = first ? (bias_ext + prod_ext) : (acc + prod_ext);
        cnt_nxt = first ? ONE : (cnt + ONE);
        last    = (first || ((state == ACC) && beat)) && (cnt_nxt == LAST);
    end

    cnn_requant_sat #(
        .SHIFT (SHIFT),
        .ACC_W (ACC_W)
    ) u_requant (
        .sum (sum_nxt),
        .q   (q)
    );

    // window FSM: accumulate beats, capture the requantized result, hold it until drained
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (first || ((state == ACC) && beat)) begin
                acc <= sum_nxt;
                cnt <= cnt_nxt;
                if (last) begin
                    out_data  <= q;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end else begin
                    out_valid <= 1'b0;
                    state     <= ACC;
                end
            end else if ((state == OUT) && drain) begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_cnn_conv_acc_relu.sv
// tb/tb_cnn_conv_acc_relu.sv - directed self-checking bench for cnn_conv_acc_relu (expectations follow CNN_ACC_RELU_EN)
module tb_cnn_conv_acc_relu;
    import cnn_acc_pkg::*;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [21:0] prod_in;
    logic        prod_valid;
    logic        prod_ready;
    logic [15:0] bias_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int nchecks = 0;
    int nerrors = 0;

    cnn_conv_acc_relu #(.ACC_LEN(9), .SHIFT(6), .ACC_W(32)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .bias_in    (bias_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive beats n0..8 of a window; a gap of idle cycles is inserted before beat gap_at
    task automatic window(input int bias, input int val, input int n0, input int gap_at, input int gap_len);
        logic [31:0] b;
        logic [31:0] v;
        b = bias;
        v = val;
        for (int i = n0; i < 9; i++) begin
            if (i == gap_at) begin
                prod_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge ap_clk); #1;
                end
                chk("gap_hold_state", 32'(dut.state), 32'(ACC));
            end
            bias_in    = b[15:0];
            prod_in    = v[21:0];
            prod_valid = 1'b1;
            @(posedge ap_clk); #1;
            if (i == 7) chk("no_early_valid", 32'(out_valid), 32'd0);
        end
        prod_valid = 1'b0;
        chk("valid_after_last", 32'(out_valid), 32'd1);
    endtask

    task automatic drain_idle();
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        chk("drained_valid", 32'(out_valid), 32'd0);
        chk("drained_state", 32'(dut.state), 32'(IDLE));
        out_ready = 1'b0;
    endtask

    initial begin
        ap_rst     = 1'b1;
        prod_in    = '0;
        prod_valid = 1'b0;
        bias_in    = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_prod_ready", 32'(prod_ready), 32'd1);
        ap_rst = 1'b0;

        // 9 x 64: 576 + 32 >> 6 = 9
        window(0, 64, 0, -1, 0);
        chk("w64_data", 32'(out_data), 32'd9);
        chk("w64_ready_low", 32'(prod_ready), 32'd0);
        drain_idle();

        // 9 x -100 with a gap: -868 >>> 6 = -14
        window(0, -100, 0, 4, 3);
`ifdef CNN_ACC_RELU_EN
        chk("wneg_data", 32'(out_data), 32'h00);
`else
        chk("wneg_data", 32'(out_data), 32'hF2);
`endif
        drain_idle();

        // 9 x 100000 saturates high
        window(0, 100000, 0, -1, 0);
        chk("wsat_data", 32'(out_data), 32'h7F);
        drain_idle();

        // bias 32, zero products: 64 >> 6 = 1
        window(32, 0, 0, -1, 0);
        chk("wround_data", 32'(out_data), 32'd1);
        drain_idle();

        // backpressure then zero-bubble restart
        window(0, 64, 0, -1, 0);
        prod_in    = 22'd64;
        prod_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge ap_clk); #1;
            chk("bp_data", 32'(out_data), 32'd9);
            chk("bp_ready", 32'(prod_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        chk("restart_state", 32'(dut.state), 32'(ACC));
        chk("restart_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        window(0, 64, 1, -1, 0);
        chk("restart_data", 32'(out_data), 32'd9);
        drain_idle();

        // reset mid-window discards the partial sum
        prod_in    = 22'd64;
        prod_valid = 1'b1;
        repeat (4) @(posedge ap_clk);
        #1;
        prod_valid = 1'b0;
        ap_rst     = 1'b1;
        #2;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
        chk("midrst_ready", 32'(prod_ready), 32'd1);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        window(0, 64, 0, -1, 0);
        chk("postrst_data", 32'(out_data), 32'd9);
        drain_idle();

        $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
        $finish;
    end

endmodule
